delay_meas_ctrl: RTL and testbench
==================================

DELAY_MEAS_CTRL -- requirements
Module: delay_meas_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of delay count.
REQ-002 SHALL have parameter TIMEOUT, default 1000, max clock edges waited for response (1..2^CNT_W-1).
REQ-003 SHALL have parameter SETTLE, default 4, clock cycles element input is held at idle level before launch (>=1).
REQ-004 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth on sense (>=2).
REQ-005 SHALL have port clk  input  1  single clock, rising-edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port start  input  1  request one measurement; sampled only in IDLE.
REQ-008 SHALL have port polarity  input  1  idle level of launch, captured at start (0: measure rising launch edge).
REQ-009 SHALL have port launch  output  1  registered drive into the inverting delay element.
REQ-010 SHALL have port sense  input  1  asynchronous output of the delay element.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.
REQ-012 SHALL have port result  output  CNT_W  measured edge count, held until next measurement completes.
REQ-013 SHALL have port timeout_flag, stuck_err  output  1 each  status qualifying result.
REQ-014 SHALL have ports res_valid output 1 / res_ready input 1 forming a valid/ready result handshake.

Function
REQ-015 SHALL implement FSM IDLE -> SETTLE -> MEASURE -> DONE -> IDLE.
REQ-016 IDLE: launch = last captured polarity; start=1 captures polarity, drives launch=polarity, goes to SETTLE.
REQ-017 SETTLE: launch held at polarity for exactly SETTLE cycles, then launch toggles to !polarity on the edge entering MEASURE.
REQ-018 If synced sense equals polarity at the last SETTLE cycle (element not at expected idle output !polarity), SHALL skip MEASURE, set stuck_err=1, result=0, go to DONE; launch not toggled.
REQ-019 MEASURE: result SHALL equal the number of rising clk edges from the edge toggling launch up to and including the edge at which synced sense first equals polarity; synchronizer latency is included, not subtracted.
REQ-020 Zero-delay element SHALL give result = SYNC_STAGES; element delayed N whole cycles SHALL give N+SYNC_STAGES.
REQ-021 If no response by edge TIMEOUT, SHALL set result=TIMEOUT, timeout_flag=1, go to DONE.
REQ-022 Response at exactly edge TIMEOUT SHALL count as success (result=TIMEOUT, timeout_flag=0).
REQ-023 DONE: res_valid=1, result/flags stable; transfer on res_valid&&res_ready; next cycle IDLE, res_valid=0.
REQ-024 On entering IDLE from DONE, launch SHALL return to captured polarity.
REQ-025 start while busy SHALL be ignored (not queued); start in the same cycle as the DONE handshake SHALL be ignored.
REQ-026 Flags SHALL clear on each new start; result SHALL update only on entry to DONE.
REQ-027 Counter SHALL not wrap; it stops at TIMEOUT.

Reset
REQ-028 rst_n low SHALL asynchronously force state IDLE, launch=0, captured polarity=0, busy=0, res_valid=0, result=0, timeout_flag=0, stuck_err=0, synchronizer flops=0, counters=0.
REQ-029 Reset mid-MEASURE SHALL abandon the measurement with no res_valid pulse.

Structure
REQ-030 Package delay_meas_pkg SHALL hold the FSM state enum and default width/timeout constants.
REQ-031 Sense synchronizer SHALL be sub-module bit_sync (parameter STAGES, clk, rst_n, d, q).

Verification
REQ-032 Zero-delay inverter model, polarity=0, start pulse -> launch rises after SETTLE+1 cycles, result=2, flags 0, res_valid held until res_ready.
REQ-033 Inverter model delayed 7 cycles, polarity=1 -> result=9, launch falls then returns to 1 after handshake.
REQ-034 sense tied to 0, polarity=0, TIMEOUT=20 -> stuck_err=1 at end of SETTLE, result=0; sense tied to 1 -> timeout_flag=1, result=20.
REQ-035 Model delay 18 cycles, TIMEOUT=20 -> result=20, timeout_flag=0.
REQ-036 rst_n asserted mid-MEASURE, start held high -> all outputs 0 immediately; start repeated during busy and at DONE handshake -> exactly one measurement.

Source files
------------

// File: rtl/delay_meas_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : delay_meas_pkg
// Description : Shared types and default constants for the delay measurement
//               controller (FSM state encoding, default widths and limits).
// Revision    : 1.0 - initial release
// ============================================================================
package delay_meas_pkg;

  localparam int unsigned C_CNT_W       = 16;
  localparam int unsigned C_TIMEOUT     = 1000;
  localparam int unsigned C_SETTLE      = 4;
  localparam int unsigned C_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETTLE  = 2'd1,
    S_MEASURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/bit_sync.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : bit_sync
// Description : Multi-flop synchronizer for a single asynchronous bit.
// Ports       : clk   - rising-edge clock
//               rst_n - asynchronous active-low reset (clears all stages)
//               d     - asynchronous input
//               q     - synchronized output (STAGES cycles of latency)
// Revision    : 1.0 - initial release
// ============================================================================
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d};
    end
  end

  assign q = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/delay_meas_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : delay_meas_ctrl
// Description : Measures the propagation delay of an external inverting
//               element in clock edges. The launch line is parked at the
//               idle level, toggled once, and the edges until the
//               synchronized response arrives are counted.
// Ports       : clk, rst_n          - clock, async active-low reset
//               start, polarity     - measurement request and idle level
//               launch, sense       - drive into / response from element
//               busy                - high outside IDLE
//               result, timeout_flag, stuck_err - measurement outcome
//               res_valid/res_ready - result handshake
// Revision    : 1.0 - initial release
// ============================================================================
module delay_meas_ctrl
  import delay_meas_pkg::*;
#(
  parameter int CNT_W       = C_CNT_W,
  parameter int TIMEOUT     = C_TIMEOUT,
  parameter int SETTLE      = C_SETTLE,
  parameter int SYNC_STAGES = C_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             polarity,
  output logic             launch,
  input  logic             sense,
  output logic             busy,
  output logic [CNT_W-1:0] result,
  output logic             timeout_flag,
  output logic             stuck_err,
  output logic             res_valid,
  input  logic             res_ready
);

  localparam int C_SW = $clog2(SETTLE + 1);
  localparam logic [C_SW-1:0]  C_SETTLE_LAST = C_SW'(SETTLE - 1);
  localparam logic [CNT_W-1:0] C_TIMEOUT_V   = CNT_W'(TIMEOUT);

  state_t            r_state;
  logic              r_pol;
  logic              r_launch;
  logic              r_busy;
  logic              r_valid;
  logic              r_tflag;
  logic              r_stuck;
  logic [CNT_W-1:0]  r_result;
  logic [CNT_W-1:0]  r_cnt;
  logic [C_SW-1:0]   r_scnt;
  logic              w_sense;

  bit_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sense),
    .q     (w_sense)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_pol    <= 1'b0;
      r_launch <= 1'b0;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
      r_tflag  <= 1'b0;
      r_stuck  <= 1'b0;
      r_result <= '0;
      r_cnt    <= '0;
      r_scnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_pol    <= polarity;
            r_launch <= polarity;
            r_tflag  <= 1'b0;
            r_stuck  <= 1'b0;
            r_scnt   <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_SETTLE;
          end
        end

        S_SETTLE: begin
          if (r_scnt == C_SETTLE_LAST) begin
            // The element must already present the inverse of the idle
            // level; otherwise the toggle could never be observed.
            if (w_sense == r_pol) begin
              r_stuck  <= 1'b1;
              r_result <= '0;
              r_valid  <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_launch <= ~r_pol;
              r_cnt    <= '0;
              r_state  <= S_MEASURE;
            end
          end else begin
            r_scnt <= r_scnt + 1'b1;
          end
        end

        S_MEASURE: begin
          // r_cnt holds the edges elapsed since the toggle; the synchronized
          // value seen here was captured on the edge that r_cnt counted last,
          // so the response check takes priority over the timeout check.
          if (w_sense == r_pol) begin
            r_result <= r_cnt;
            r_valid  <= 1'b1;
            r_state  <= S_DONE;
          end else if (r_cnt == C_TIMEOUT_V) begin
            r_result <= C_TIMEOUT_V;
            r_tflag  <= 1'b1;
            r_valid  <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_DONE: begin
          if (res_ready) begin
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_launch <= r_pol;
            r_state  <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign launch       = r_launch;
  assign busy         = r_busy;
  assign res_valid    = r_valid;
  assign result       = r_result;
  assign timeout_flag = r_tflag;
  assign stuck_err    = r_stuck;

endmodule
`default_nettype wire

// File: tb/tb_delay_meas_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_delay_meas_ctrl
// Description : Scoreboard bench for delay_meas_ctrl. A configurable element
//               model (delayed inverter, or sense tied low/high) sits on the
//               launch/sense loop. Expected outcomes come from a rule-based
//               model of the measurement and are compared at each result
//               handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_delay_meas_ctrl;

  localparam int CNT_W       = 16;
  localparam int TIMEOUT     = 20;
  localparam int SETTLE      = 4;
  localparam int SYNC_STAGES = 2;

  typedef struct {
    logic [CNT_W-1:0] res;
    logic             tf;
    logic             st;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             polarity;
  logic             launch;
  logic             sense;
  logic             busy;
  logic [CNT_W-1:0] result;
  logic             timeout_flag;
  logic             stuck_err;
  logic             res_valid;
  logic             res_ready;

  int               n_vec = 0;
  int               n_err = 0;
  exp_t             sb[$];
  bit               lastpol = 1'b0;

  // element model: 0 = inverter delayed dly cycles, 1 = tied 0, 2 = tied 1
  int               mode = 0;
  int               dly  = 0;
  logic [31:0]      dl;

  delay_meas_ctrl #(
    .CNT_W       (CNT_W),
    .TIMEOUT     (TIMEOUT),
    .SETTLE      (SETTLE),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .polarity     (polarity),
    .launch       (launch),
    .sense        (sense),
    .busy         (busy),
    .result       (result),
    .timeout_flag (timeout_flag),
    .stuck_err    (stuck_err),
    .res_valid    (res_valid),
    .res_ready    (res_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) dl <= {dl[30:0], launch};

  always_comb begin
    sense = 1'b0;
    case (mode)
      1:       sense = 1'b0;
      2:       sense = 1'b1;
      default: sense = (dly == 0) ? ~launch : ~dl[dly-1];
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Outcome from the measurement rules. An inverter response reaches the
  // controller's decision point SYNC_STAGES+1 edges after the element output
  // moves, so a polarity change with a slow element is seen as stuck.
  function automatic exp_t model(input bit pol, input bit lp, input int md, input int n);
    exp_t e;
    bit   lvl;
    e.res = '0;
    e.tf  = 1'b0;
    e.st  = 1'b0;
    lvl   = (md == 2);
    if (md == 1 || md == 2) begin
      if (lvl == pol) e.st = 1'b1;
      else begin
        e.res = CNT_W'(TIMEOUT);
        e.tf  = 1'b1;
      end
    end else if (pol != lp && n + SYNC_STAGES + 1 > SETTLE) begin
      e.st = 1'b1;
    end else if (n + SYNC_STAGES <= TIMEOUT) begin
      e.res = CNT_W'(n + SYNC_STAGES);
    end else begin
      e.res = CNT_W'(TIMEOUT);
      e.tf  = 1'b1;
    end
    return e;
  endfunction

  // monitor: every handshake pops one expectation
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 32'(res_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result",       32'(result),       32'(e.res));
        chk("timeout_flag", 32'(timeout_flag), 32'(e.tf));
        chk("stuck_err",    32'(stuck_err),    32'(e.st));
      end
    end
  end

  task automatic settle_element(input int md, input int n);
    mode = md;
    dly  = n;
    repeat (40) @(posedge clk);
    #1;
  endtask

  task automatic run_meas(input bit pol, input int md, input int n);
    exp_t e;
    int   k;
    settle_element(md, n);
    e = model(pol, lastpol, md, n);
    sb.push_back(e);
    lastpol  = pol;
    polarity = pol;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    polarity = 1'($urandom_range(0, 1));
    chk("busy_after_start", 32'(busy), 32'd1);
    k = 0;
    while (!res_valid && k < TIMEOUT + SETTLE + 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("res_valid_seen", 32'(res_valid), 32'd1);
    chk("launch_in_done", 32'(launch), 32'(e.st ? pol : !pol));
    k = 0;
    while (busy && k < 100) begin
      res_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      k++;
    end
    res_ready = 1'b0;
    chk("idle_after_handshake", 32'(busy), 32'd0);
    chk("launch_restored", 32'(launch), 32'(pol));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got 0 expected 1");
    $fatal(1, "watchdog");
  end

  initial begin
    int   k;
    exp_t e;
    rst_n     = 1'b0;
    start     = 1'b0;
    polarity  = 1'b0;
    res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_launch",    32'(launch),       32'd0);
    chk("rst_busy",      32'(busy),         32'd0);
    chk("rst_valid",     32'(res_valid),    32'd0);
    chk("rst_result",    32'(result),       32'd0);
    chk("rst_tflag",     32'(timeout_flag), 32'd0);
    chk("rst_stuck",     32'(stuck_err),    32'd0);
    rst_n = 1'b1;

    // zero-delay inverter, polarity 0: launch timing and held result
    settle_element(0, 0);
    e = model(1'b0, lastpol, 0, 0);
    sb.push_back(e);
    lastpol  = 1'b0;
    polarity = 1'b0;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    repeat (SETTLE - 1) @(posedge clk);
    #1;
    chk("launch_before_toggle", 32'(launch), 32'd0);
    @(posedge clk); #1;
    chk("launch_toggled", 32'(launch), 32'd1);
    k = 0;
    while (!res_valid && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    chk("zero_delay_valid", 32'(res_valid), 32'd1);
    repeat (5) begin
      @(posedge clk); #1;
      chk("valid_held", 32'(res_valid), 32'd1);
      chk("result_held", 32'(result), 32'd2);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("valid_dropped", 32'(res_valid), 32'd0);
    chk("busy_dropped", 32'(busy), 32'd0);

    // polarity change to 1 with a slow element reads as stuck, then 9
    run_meas(1'b1, 0, 7);
    run_meas(1'b1, 0, 7);
    // tied sense
    run_meas(1'b0, 1, 0);
    run_meas(1'b0, 2, 0);
    // timeout boundary
    run_meas(1'b0, 0, 18);
    run_meas(1'b0, 0, 19);

    // reset mid-MEASURE with start held high
    settle_element(0, 10);
    polarity = lastpol;
    start    = 1'b1;
    @(posedge clk); #1;
    repeat (SETTLE + 3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_launch", 32'(launch),       32'd0);
    chk("midrst_busy",   32'(busy),         32'd0);
    chk("midrst_valid",  32'(res_valid),    32'd0);
    chk("midrst_result", 32'(result),       32'd0);
    chk("midrst_tflag",  32'(timeout_flag), 32'd0);
    chk("midrst_stuck",  32'(stuck_err),    32'd0);
    start   = 1'b0;
    sb.delete();
    lastpol = 1'b0;
    @(posedge clk); @(posedge clk);
    #2;
    rst_n = 1'b1;

    // start held during busy and asserted on the handshake edge
    settle_element(0, 3);
    sb.push_back(model(lastpol, lastpol, 0, 3));
    polarity = lastpol;
    start    = 1'b1;
    k = 0;
    while (!res_valid && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
    chk("repeat_valid_seen", 32'(res_valid), 32'd1);
    res_ready = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    res_ready = 1'b0;
    chk("start_at_handshake_ignored", 32'(busy), 32'd0);
    repeat (60) @(posedge clk);
    #1;
    chk("no_second_measurement", 32'(busy), 32'd0);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    // randomized measurements
    for (int i = 0; i < 30; i++) begin
      int md;
      md = ($urandom_range(0, 9) < 7) ? 0 : int'($urandom_range(1, 2));
      run_meas(1'($urandom_range(0, 1)), md, int'($urandom_range(0, 22)));
    end

    repeat (5) @(posedge clk);
    #1;
    chk("final_scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
